// File: rtl/mem_wb_pkg.sv
// Shared types and default widths for the MEM/WB pipeline boundary.
// Entry layout and the entry-construction rule live here so both entry registers agree.
package mem_wb_pkg;

  localparam int DATA_W     = 24;
  localparam int REG_ADDR_W = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } wb_state_t;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     wdata;
  } wb_entry_t;

  // Register 0 is hard-wired, so an instruction targeting it never asserts we.
  function automatic wb_entry_t make_entry(
    input logic                  we,
    input logic                  mem_read,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [DATA_W-1:0]     alu_result,
    input logic [DATA_W-1:0]     mem_data
  );
    wb_entry_t e;
    e.valid = 1'b1;
    e.we    = we & (rd != '0);
    e.rd    = rd;
    e.wdata = mem_read ? mem_data : alu_result;
    return e;
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Memory-stage to writeback-stage result channel.
// Handshake: a transfer happens on a rising clk edge where in_valid & in_ready are both 1;
// while in_valid=1 and in_ready=0 the master must hold in_valid and all payload stable.
interface mem_wb_stage_if;
  import mem_wb_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic                  in_writeback_enable;
  logic                  in_mem_read_enable;
  logic [DATA_W-1:0]     in_alu_result;
  logic [DATA_W-1:0]     in_mem_data;
  logic [REG_ADDR_W-1:0] in_rd;

  modport master (
    output in_valid,
    output in_writeback_enable,
    output in_mem_read_enable,
    output in_alu_result,
    output in_mem_data,
    output in_rd,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_writeback_enable,
    input  in_mem_read_enable,
    input  in_alu_result,
    input  in_mem_data,
    input  in_rd,
    output in_ready
  );

endinterface

// File: rtl/mem_wb_stage_entry_reg.sv
// One writeback entry register with load enable and synchronous clear.
// Clear wins over load so a flush can never be overridden by a same-cycle capture.
module wb_entry_reg
  import mem_wb_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      load_i,
  input  logic      clear_i,
  input  wb_entry_t d_i,
  output wb_entry_t q_o
);

  wb_entry_t entry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= '0;
    end else if (clear_i) begin
      entry_q <= '0;
    end else if (load_i) begin
      entry_q <= d_i;
    end
  end

  assign q_o = entry_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB boundary: output entry drives the register-file write port, a skid entry
// absorbs one extra result while the port stalls, and the youngest pending write is forwarded.
module mem_wb_stage
  import mem_wb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  mem_wb_stage_if.slave         in_if,
  input  logic                  flush,
  input  logic                  wb_stall,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0]     fwd_data,
  output logic [15:0]           wb_count,
  output wb_state_t             state_o
);

  wb_state_t   state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic [15:0] wb_count_q, wb_count_d;

  wb_entry_t   out_e, skid_e, new_e, out_d;
  logic        out_load, out_clr, skid_load, skid_clr;
  logic        accept, drain;

  assign accept = in_if.in_valid & in_ready_q;
  assign drain  = !wb_stall;

  assign new_e = make_entry(in_if.in_writeback_enable, in_if.in_mem_read_enable,
                            in_if.in_rd, in_if.in_alu_result, in_if.in_mem_data);

  wb_entry_reg u_out_entry (
    .clk     (clk),
    .rst_n   (rst),
    .load_i  (out_load),
    .clear_i (out_clr),
    .d_i     (out_d),
    .q_o     (out_e)
  );

  wb_entry_reg u_skid_entry (
    .clk     (clk),
    .rst_n   (rst),
    .load_i  (skid_load),
    .clear_i (skid_clr),
    .d_i     (new_e),
    .q_o     (skid_e)
  );

  // in_ready_d is computed alongside the state so in_ready can be a plain flop.
  always_comb begin
    state_d    = state_q;
    in_ready_d = in_ready_q;
    out_d      = new_e;
    out_load   = 1'b0;
    out_clr    = 1'b0;
    skid_load  = 1'b0;
    skid_clr   = 1'b0;
    if (flush) begin
      state_d    = EMPTY;
      in_ready_d = 1'b1;
      out_clr    = 1'b1;
      skid_clr   = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d  = FULL;
            out_load = 1'b1;
          end
        end
        FULL: begin
          if (accept) begin
            if (drain) begin
              out_load = 1'b1;
            end else begin
              state_d    = SKID;
              skid_load  = 1'b1;
              in_ready_d = 1'b0;
            end
          end else if (drain) begin
            state_d = EMPTY;
            out_clr = 1'b1;
          end
        end
        SKID: begin
          if (drain) begin
            state_d    = FULL;
            out_d      = skid_e;
            out_load   = 1'b1;
            skid_clr   = 1'b1;
            in_ready_d = 1'b1;
          end
        end
        default: begin
          state_d    = EMPTY;
          in_ready_d = 1'b1;
          out_clr    = 1'b1;
          skid_clr   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      wb_count_q <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      wb_count_q <= wb_count_d;
    end
  end

  // A flush cycle never writes, even if the port happens to be free.
  assign rf_we      = out_e.valid & out_e.we & drain & !flush;
  assign rf_waddr   = out_e.valid ? out_e.rd    : '0;
  assign rf_wdata   = out_e.valid ? out_e.wdata : '0;
  assign wb_count_d = rf_we ? wb_count_q + 16'd1 : wb_count_q;

  always_comb begin
    fwd_valid = 1'b0;
    fwd_rd    = '0;
    fwd_data  = '0;
    if (skid_e.valid && skid_e.we) begin
      fwd_valid = 1'b1;
      fwd_rd    = skid_e.rd;
      fwd_data  = skid_e.wdata;
    end else if (out_e.valid && out_e.we) begin
      fwd_valid = 1'b1;
      fwd_rd    = out_e.rd;
      fwd_data  = out_e.wdata;
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign wb_count       = wb_count_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: a queue model of pending writes checked every negedge,
// directed scenarios with literal expectations, randomized traffic and a counter wrap.
module tb_mem_wb_stage;
  import mem_wb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic wb_stall = 1'b0;

  always #5 clk = ~clk;

  mem_wb_stage_if bus ();

  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]     rf_wdata;
  logic                  fwd_valid;
  logic [REG_ADDR_W-1:0] fwd_rd;
  logic [DATA_W-1:0]     fwd_data;
  logic [15:0]           wb_count;
  wb_state_t             state_o;

  mem_wb_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_if     (bus.slave),
    .flush     (flush),
    .wb_stall  (wb_stall),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .fwd_valid (fwd_valid),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .wb_count  (wb_count),
    .state_o   (state_o)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Pending writes, oldest first: {we, rd, data}. At most two can be held.
  logic [28:0] exp_q[$];
  logic        m_ready;
  logic [15:0] m_count;
  logic        m_acc, m_drain;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      m_ready = 1'b1;
      m_count = 16'd0;
    end else begin
      if (exp_q.size() > 0 && exp_q[0][28] && !wb_stall && !flush) m_count = m_count + 16'd1;
      if (flush) begin
        exp_q.delete();
        m_ready = 1'b1;
      end else begin
        m_acc   = bus.in_valid && m_ready;
        m_drain = exp_q.size() > 0 && !wb_stall;
        if (m_drain) void'(exp_q.pop_front());
        if (m_acc)
          exp_q.push_back({bus.in_writeback_enable && (bus.in_rd != 4'd0), bus.in_rd,
                           bus.in_mem_read_enable ? bus.in_mem_data : bus.in_alu_result});
        m_ready = exp_q.size() < 2;
      end
    end
  end

  always @(negedge clk) begin
    if (rst && chk_en) begin
      logic        e_we, e_fv;
      logic [3:0]  e_addr, e_frd;
      logic [23:0] e_data, e_fdata;
      logic [1:0]  e_state;
      e_we = 1'b0; e_addr = '0; e_data = '0;
      e_fv = 1'b0; e_frd = '0; e_fdata = '0;
      if (exp_q.size() > 0) begin
        e_we   = exp_q[0][28] && !wb_stall && !flush;
        e_addr = exp_q[0][27:24];
        e_data = exp_q[0][23:0];
      end
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (!e_fv && exp_q[i][28]) begin
          e_fv    = 1'b1;
          e_frd   = exp_q[i][27:24];
          e_fdata = exp_q[i][23:0];
        end
      end
      e_state = (exp_q.size() == 0) ? 2'd0 : (exp_q.size() == 1) ? 2'd1 : 2'd2;
      check("rf_we",     32'(rf_we),     32'(e_we));
      check("rf_waddr",  32'(rf_waddr),  32'(e_addr));
      check("rf_wdata",  32'(rf_wdata),  32'(e_data));
      check("fwd_valid", 32'(fwd_valid), 32'(e_fv));
      check("fwd_rd",    32'(fwd_rd),    32'(e_frd));
      check("fwd_data",  32'(fwd_data),  32'(e_fdata));
      check("in_ready",  32'(bus.in_ready), 32'(m_ready));
      check("wb_count",  32'(wb_count),  32'(m_count));
      check("state",     32'(state_o),   32'(e_state));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic v, input logic we, input logic mr,
                        input logic [23:0] alu, input logic [23:0] mem, input logic [3:0] rd);
    bus.in_valid            = v;
    bus.in_writeback_enable = we;
    bus.in_mem_read_enable  = mr;
    bus.in_alu_result       = alu;
    bus.in_mem_data         = mem;
    bus.in_rd               = rd;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 4'd0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    flush    = 1'b0;
    wb_stall = 1'b0;
    rst      = 1'b0;
    #30;
    rst = 1'b1;
    cyc();
  endtask

  task automatic fill_skid();
    wb_stall = 1'b1;
    set_in(1'b1, 1'b1, 1'b0, 24'h11, 24'h0, 4'd1);
    cyc();
    set_in(1'b1, 1'b1, 1'b0, 24'h22, 24'h0, 4'd2);
    cyc();
    idle();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic hold;
    idle();
    chk_en = 1'b1;
    rst = 1'b0;
    #30;
    rst = 1'b1;
    cyc();

    check("rst_in_ready",  32'(bus.in_ready), 32'd1);
    check("rst_rf_we",     32'(rf_we),     32'd0);
    check("rst_rf_waddr",  32'(rf_waddr),  32'd0);
    check("rst_rf_wdata",  32'(rf_wdata),  32'd0);
    check("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    check("rst_wb_count",  32'(wb_count),  32'd0);
    check("rst_state",     32'(state_o),   32'(EMPTY));

    // Load path
    set_in(1'b1, 1'b1, 1'b1, 24'h000001, 24'h000ABC, 4'd3);
    cyc();
    idle();
    check("load_rf_we",    32'(rf_we),    32'd1);
    check("load_rf_waddr", 32'(rf_waddr), 32'd3);
    check("load_rf_wdata", 32'(rf_wdata), 32'h000ABC);
    check("load_fwd_rd",   32'(fwd_rd),   32'd3);
    cyc();
    check("load_wb_count", 32'(wb_count), 32'd1);

    // ALU path, then rd=0
    set_in(1'b1, 1'b1, 1'b0, 24'h000002, 24'hFFFFFF, 4'd5);
    cyc();
    idle();
    check("alu_rf_wdata", 32'(rf_wdata), 32'h000002);
    check("alu_rf_we",    32'(rf_we),    32'd1);
    cyc();
    set_in(1'b1, 1'b1, 1'b0, 24'h000007, 24'h0, 4'd0);
    cyc();
    idle();
    check("rd0_rf_we",     32'(rf_we),     32'd0);
    check("rd0_fwd_valid", 32'(fwd_valid), 32'd0);
    cyc();
    check("rd0_wb_count",  32'(wb_count),  32'd2);

    // Stall and skid
    do_reset();
    fill_skid();
    check("skid_in_ready", 32'(bus.in_ready), 32'd0);
    check("skid_fwd_rd",   32'(fwd_rd),   32'd2);
    check("skid_fwd_data", 32'(fwd_data), 32'h22);
    check("skid_rf_we",    32'(rf_we),    32'd0);
    wb_stall = 1'b0;
    #1;
    check("drainA_rf_we",    32'(rf_we),    32'd1);
    check("drainA_rf_waddr", 32'(rf_waddr), 32'd1);
    check("drainA_rf_wdata", 32'(rf_wdata), 32'h11);
    cyc();
    check("drainB_in_ready", 32'(bus.in_ready), 32'd1);
    check("drainB_rf_waddr", 32'(rf_waddr), 32'd2);
    check("drainB_rf_wdata", 32'(rf_wdata), 32'h22);
    cyc();
    check("drain_wb_count",  32'(wb_count), 32'd2);

    // Flush while in SKID with an input offered
    do_reset();
    fill_skid();
    flush    = 1'b1;
    wb_stall = 1'b0;
    set_in(1'b1, 1'b1, 1'b0, 24'h33, 24'h0, 4'd7);
    #1;
    check("flush_rf_we", 32'(rf_we), 32'd0);
    cyc();
    flush = 1'b0;
    idle();
    check("flush_in_ready",  32'(bus.in_ready), 32'd1);
    check("flush_fwd_valid", 32'(fwd_valid), 32'd0);
    check("flush_state",     32'(state_o),   32'(EMPTY));
    cyc();
    check("flush_wb_count",  32'(wb_count), 32'd0);

    // Asynchronous reset in the middle of a stalled cycle
    do_reset();
    fill_skid();
    #2;
    rst = 1'b0;
    #1;
    check("arst_in_ready",  32'(bus.in_ready), 32'd1);
    check("arst_fwd_valid", 32'(fwd_valid), 32'd0);
    check("arst_rf_waddr",  32'(rf_waddr),  32'd0);
    check("arst_state",     32'(state_o),   32'(EMPTY));
    #3;
    rst = 1'b1;
    wb_stall = 1'b0;
    repeat (3) begin
      cyc();
      check("arst_no_write", 32'(rf_we), 32'd0);
    end
    check("arst_wb_count", 32'(wb_count), 32'd0);

    // Randomized traffic; upstream holds a refused offer until accepted
    do_reset();
    repeat (3000) begin
      hold = bus.in_valid && !bus.in_ready && !flush;
      cyc();
      if (!hold)
        set_in($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)),
               24'($urandom), 24'($urandom), 4'($urandom_range(0, 15)));
      wb_stall = ($urandom_range(0, 2) == 0);
      flush    = ($urandom_range(0, 39) == 0);
    end
    cyc();
    flush    = 1'b0;
    wb_stall = 1'b0;
    idle();
    repeat (3) cyc();

    // Counter wrap: 65536 back-to-back writes
    do_reset();
    for (int i = 0; i < 65536; i++) begin
      set_in(1'b1, 1'b1, 1'($urandom_range(0, 1)), 24'($urandom), 24'($urandom),
             4'($urandom_range(1, 15)));
      cyc();
    end
    idle();
    cyc();
    check("wrap_wb_count", 32'(wb_count), 32'd0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipeline boundary between the memory stage and the register-file writeback.
- Captures each memory-stage result, selects writeback data (memory load data or ALU result), and drives the register-file write port.
- Exposes the in-flight result as a forwarding source for EX.
- A one-entry skid buffer keeps in_ready registered while the register-file port stalls the stage.

Parameters:
- DATA_W, 24, datapath width
- REG_ADDR_W, 4, register index width

Ports:
- clk  in  1  stage clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  memory stage presents a result
- in_ready  out  1  stage accepts this cycle (registered)
- in_writeback_enable  in  1  instruction writes a register
- in_mem_read_enable  in  1  instruction is a load
- in_alu_result  in  DATA_W  ALU result passed through MEM
- in_mem_data  in  DATA_W  load data (memory_stage_out)
- in_rd  in  REG_ADDR_W  destination register
- flush  in  1  discard all held entries
- wb_stall  in  1  register-file port busy; hold output entry
- rf_we  out  1  register-file write enable
- rf_waddr  out  REG_ADDR_W  write address
- rf_wdata  out  DATA_W  write data
- fwd_valid  out  1  forwarding data valid
- fwd_rd  out  REG_ADDR_W  forwarding destination
- fwd_data  out  DATA_W  forwarding value
- wb_count  out  16  retired register writes, wraps

Behaviour:
- **Reset.** rst low asynchronously sets:
  - state=EMPTY, in_ready=1, both entries invalid
  - rf_we=0, rf_waddr=0, rf_wdata=0
  - fwd_valid=0, fwd_rd=0, fwd_data=0
  - wb_count=0
  - Reset mid-stall discards both entries; no write occurs.
- **Capture.** On accept (in_valid & in_ready), the entry stores:
  - wdata = in_mem_read_enable ? in_mem_data : in_alu_result
  - rd, we = in_writeback_enable & (in_rd != 0); register 0 is never written
  - Entries with we=0 still occupy a slot and drain normally.
- **Output (combinational from output entry).**
  - rf_we = out_valid & out_we & !wb_stall; rf_waddr = out_rd; rf_wdata = out_wdata.
  - rf_waddr and rf_wdata are 0 when out_valid=0.
  - Latency: accepted at edge N, rf_we high in the cycle after edge N if not stalled.
- **FSM states** (drain = !wb_stall):
  - EMPTY: accept -> FULL (load output entry); else stay.
  - FULL, accept & drain -> FULL, output entry replaced.
  - FULL, accept & !drain -> SKID, skid entry loaded; in_ready=0 from the next cycle.
  - FULL, !accept & drain -> EMPTY.
  - FULL, !accept & !drain -> stay.
  - SKID: in_ready=0. drain -> FULL, skid moves to output, in_ready=1 next cycle; else stay.
- **in_ready** is a register: 1 in EMPTY/FULL, 0 in SKID.
- **Flush.**
  - Synchronous; takes priority over everything. Next state=EMPTY, both entries invalid, in_ready=1.
  - An input offered in the flush cycle is dropped.
  - rf_we is forced 0 in the flush cycle.
- **Forwarding.**
  - Youngest valid entry with we=1 wins: skid entry if valid & we, else output entry if valid & we.
  - fwd_valid=0 otherwise, with fwd_rd/fwd_data=0.
- **wb_count** increments by 1 on each cycle with rf_we=1; 16'hFFFF wraps to 0.
- **Simultaneous events.**
  - wb_stall and flush together: flush wins.
  - in_valid=1 while in SKID: not accepted; upstream must hold its data.

Decomposition:
- Package mem_wb_pkg holds:
  - DATA_W and REG_ADDR_W defaults
  - typedef enum {EMPTY, FULL, SKID} wb_state_t
  - packed struct wb_entry_t {valid, we, rd, wdata}
- One sub-module, wb_entry_reg: an enable/clear register of wb_entry_t with asynchronous active-low reset. It is instantiated twice (output and skid).

Test Plan:
- Reset then load: rst low 30ns, release; offer we=1, mem_read=1, mem_data=24'h000ABC, alu=24'h1, rd=3 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=24'h000ABC, wb_count=1.
- ALU path: we=1, mem_read=0, alu=24'h000002, rd=5 -> rf_wdata=24'h000002; rd=0 variant -> rf_we=0, fwd_valid=0, wb_count unchanged.
- Stall and skid:
  - Stimulus: wb_stall=1; accept A (rd=1, 24'h11), then B (rd=2, 24'h22).
  - Response: in_ready=0 after B; fwd_rd=2, fwd_data=24'h22.
  - Release stall: A written, then B, in that order; in_ready=1 after A drains; wb_count=2.
- Flush in SKID: state SKID with two entries, flush=1 with in_valid=1 -> no rf_we, in_ready=1, fwd_valid=0 next cycle, incoming dropped.
- Asynchronous reset mid-stall: hold wb_stall=1 with an entry in SKID, pulse rst low between clock edges -> outputs reset immediately; no write after release.
- Counter wrap: force 65536 back-to-back writes -> wb_count returns to 0.
